// File: rtl/dns_arb_pkg.sv
// Shared types and constants for the DNS client arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   DNS_*_W     : default field widths of the lookup-engine interface
//   sat_inc     : saturating increment used by the latency counter
package dns_arb_pkg;

  localparam int DNS_ADDR_W = 8;
  localparam int DNS_IP_W   = 8;
  localparam int DNS_IDX_W  = 16;
  localparam int LAT_W      = 8;

  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (v == LAT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dns_rr_pick.sv
// Combinational round-robin selector.
//   req_i        : request vector, one bit per client
//   last_grant_i : client served most recently (lowest priority now)
//   grant_o      : first requesting client found searching upward from
//                  last_grant_i+1 with wrap-around
//   any_req_o    : at least one request bit is set
module dns_rr_pick #(
  parameter  int NUM_CLIENTS = 4,
  localparam int GW          = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [GW-1:0]          last_grant_i,
  output logic [GW-1:0]          grant_o,
  output logic                   any_req_o
);

  // Distance of client i from the head of the rotating priority order;
  // the client right after last_grant has distance 0.
  function automatic int rr_dist(input int i, input int last);
    return (i + NUM_CLIENTS - 1 - last) % NUM_CLIENTS;
  endfunction

  int best_dist;

  // NOTE: every output of a combinational block gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    best_dist = NUM_CLIENTS;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (req_i[i] && (rr_dist(i, int'(last_grant_i)) < best_dist)) begin
        best_dist = rr_dist(i, int'(last_grant_i));
        grant_o   = GW'(i);
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dns_client_arbiter.sv
// Shares one DNS lookup engine between NUM_CLIENTS requesters.
// Round-robin grant, one-cycle dns_req pulse, bounded wait for dns_res,
// then a one-cycle cli_ack to the granted client with the result.
//   clk, rst            : clock, synchronous active-high reset
//   cli_req / cli_addr  : per-client level request and packed addresses
//   cli_ack             : one-hot completion pulse
//   cli_ip/idx/err/lat  : result fields, valid only with cli_ack (else 0)
//   dns_req / dns_addr  : request pulse and address to the engine
//   dns_res/ip/idx      : engine completion pulse and result
//   busy, grant_id      : activity flag and index of the client in service
module dns_client_arbiter
  import dns_arb_pkg::*;
#(
  parameter  int NUM_CLIENTS    = 4,
  parameter  int ADDR_W         = DNS_ADDR_W,
  parameter  int IDX_W          = DNS_IDX_W,
  parameter  int TIMEOUT_CYCLES = 200,
  localparam int GW             = $clog2(NUM_CLIENTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        cli_req,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
  output logic [NUM_CLIENTS-1:0]        cli_ack,
  output logic [DNS_IP_W-1:0]           cli_ip,
  output logic [IDX_W-1:0]              cli_idx,
  output logic                          cli_err,
  output logic [LAT_W-1:0]              cli_lat,
  output logic                          dns_req,
  output logic [ADDR_W-1:0]             dns_addr,
  input  logic                          dns_res,
  input  logic [DNS_IP_W-1:0]           dns_ip,
  input  logic [IDX_W-1:0]              dns_idx,
  output logic                          busy,
  output logic [GW-1:0]                 grant_id
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_e               state_q;
  logic [GW-1:0]            grant_q;
  logic [GW-1:0]            last_grant_q;
  logic [ADDR_W-1:0]        addr_q;
  logic                     req_q;
  logic                     busy_q;
  logic [NUM_CLIENTS-1:0]   ack_q;
  logic [DNS_IP_W-1:0]      ip_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     err_q;
  logic [LAT_W-1:0]         lat_out_q;
  logic [7:0]               timer_q;
  logic [LAT_W-1:0]         lat_q;

  logic [GW-1:0]            pick_grant_d;
  logic                     any_req_d;
  logic [ADDR_W-1:0]        sel_addr_d;

  dns_rr_pick #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_pick (
    .req_i        (cli_req),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant_d),
    .any_req_o    (any_req_d)
  );

  // Address of the client the selector would grant this cycle.
  always_comb begin
    sel_addr_d = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_grant_d == GW'(i)) sel_addr_d = cli_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_CLIENTS - 1);
      addr_q       <= '0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= '0;
      ip_q         <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      lat_out_q    <= '0;
      timer_q      <= '0;
      lat_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // dns_res is deliberately ignored here: it may be a stale reply
          // from a lookup abandoned by reset.
          if (any_req_d) begin
            grant_q <= pick_grant_d;
            addr_q  <= sel_addr_d;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          req_q   <= 1'b0;
          timer_q <= '0;
          lat_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          lat_q <= sat_inc(lat_q);
          // A reply on the timeout cycle takes precedence over the timeout.
          if (dns_res) begin
            ack_q     <= NUM_CLIENTS'(1) << grant_q;
            ip_q      <= dns_ip;
            idx_q     <= dns_idx;
            err_q     <= 1'b0;
            lat_out_q <= sat_inc(lat_q);
            state_q   <= RESP;
          end else if (timer_q == TIMER_LAST) begin
            ack_q     <= NUM_CLIENTS'(1) << grant_q;
            ip_q      <= '0;
            idx_q     <= '0;
            err_q     <= 1'b1;
            lat_out_q <= sat_inc(lat_q);
            state_q   <= RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          // Result fields return to zero together with the ack.
          ack_q        <= '0;
          ip_q         <= '0;
          idx_q        <= '0;
          err_q        <= 1'b0;
          lat_out_q    <= '0;
          last_grant_q <= grant_q;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cli_ack  = ack_q;
  assign cli_ip   = ip_q;
  assign cli_idx  = idx_q;
  assign cli_err  = err_q;
  assign cli_lat  = lat_out_q;
  assign dns_req  = req_q;
  assign dns_addr = addr_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule
